// File: rtl/bcd_alu_seq_if.sv
// Start/done handshake plus operand and result bundle for the sequential BCD ALU.
// The master side sits in the operand registers, the slave side is the ALU.
interface bcd_alu_seq_if #(
    parameter int DIGIT_NUM = 8,
    parameter int DP_W      = 3
);
    logic                   start;
    logic [2:0]             op;
    logic                   a_sign;
    logic                   b_sign;
    logic [4*DIGIT_NUM-1:0] a;
    logic [4*DIGIT_NUM-1:0] b;
    logic [DP_W-1:0]        a_dp;
    logic [DP_W-1:0]        b_dp;
    logic                   busy;
    logic                   done;
    logic [4*DIGIT_NUM-1:0] result;
    logic                   result_sign;
    logic [DP_W-1:0]        result_dp;
    logic                   overflow;
    logic                   err;

    modport master (
        output start, op, a_sign, b_sign, a, b, a_dp, b_dp,
        input  busy, done, result, result_sign, result_dp, overflow, err
    );

    modport slave (
        input  start, op, a_sign, b_sign, a, b, a_dp, b_dp,
        output busy, done, result, result_sign, result_dp, overflow, err
    );
endinterface

// File: rtl/bcd_alu_seq.sv
// Multi-cycle signed BCD add/sub/mul/div with decimal-point alignment, normalisation
// and double-dabble output conversion, under a start/done handshake.
module bcd_alu_seq #(
    parameter int DIGIT_NUM   = 8,
    parameter int DP_W        = 3,
    parameter int FRAC_DIGITS = 4,
    parameter int IW          = 64
) (
    input logic          clk,
    input logic          rst_n,
    bcd_alu_seq_if.slave bus
);
    localparam int MW = 4 * DIGIT_NUM;
    localparam int XW = 8;
    localparam int CW = $clog2(IW + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SCALE = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_NORM  = 3'd4;
    localparam logic [2:0] S_CONV  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    function automatic logic [IW-1:0] pow10(input int unsigned n);
        logic [IW-1:0] p;
        p = IW'(1);
        for (int unsigned i = 0; i < n; i++) p = p * IW'(10);
        return p;
    endfunction

    function automatic logic [IW-1:0] times10(input logic [IW-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

    localparam logic [IW-1:0] LIMIT = pow10(DIGIT_NUM);

    logic [2:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [MW-1:0]   a_bcd_q, a_bcd_d, b_bcd_q, b_bcd_d;
    logic [DP_W-1:0] a_dp_q, a_dp_d, b_dp_q, b_dp_d;
    logic [IW-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d, r_mag_q, r_mag_d;
    logic [MW-1:0]   rem_q, rem_d, bcd_q, bcd_d;
    logic [XW-1:0]   dp_q, dp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            bad_q, bad_d, scale_a_q, scale_a_d, r_sign_q, r_sign_d;
    logic [MW-1:0]   result_q, result_d;
    logic            result_sign_q, result_sign_d;
    logic [DP_W-1:0] result_dp_q, result_dp_d;
    logic            overflow_q, overflow_d, err_q, err_d;

    logic [3:0]      dig_a, dig_b, dg;
    logic            cy, b_neg, settle, big, carry_ovf;
    logic [XW-1:0]   k;
    logic [IW:0]     sum;
    logic [MW:0]     rem_sh, diff;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_sign_d      = a_sign_q;
        b_sign_d      = b_sign_q;
        a_bcd_d       = a_bcd_q;
        b_bcd_d       = b_bcd_q;
        a_dp_d        = a_dp_q;
        b_dp_d        = b_dp_q;
        a_mag_d       = a_mag_q;
        b_mag_d       = b_mag_q;
        r_mag_d       = r_mag_q;
        rem_d         = rem_q;
        bcd_d         = bcd_q;
        dp_d          = dp_q;
        cnt_d         = cnt_q;
        bad_d         = bad_q;
        scale_a_d     = scale_a_q;
        r_sign_d      = r_sign_q;
        result_d      = result_q;
        result_sign_d = result_sign_q;
        result_dp_d   = result_dp_q;
        overflow_d    = overflow_q;
        err_d         = err_q;
        dig_a         = '0;
        dig_b         = '0;
        dg            = '0;
        cy            = 1'b0;
        b_neg         = 1'b0;
        settle        = 1'b0;
        big           = 1'b0;
        carry_ovf     = 1'b0;
        k             = '0;
        sum           = '0;
        rem_sh        = '0;
        diff          = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_LOAD;
                    op_d       = bus.op;
                    a_sign_d   = bus.a_sign;
                    b_sign_d   = bus.b_sign;
                    a_bcd_d    = bus.a;
                    b_bcd_d    = bus.b;
                    a_dp_d     = bus.a_dp;
                    b_dp_d     = bus.b_dp;
                    a_mag_d    = '0;
                    b_mag_d    = '0;
                    bad_d      = 1'b0;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                    err_d      = 1'b0;
                end
            end

            S_LOAD: begin
                dig_a   = a_bcd_q[MW-1 -: 4];
                dig_b   = b_bcd_q[MW-1 -: 4];
                a_mag_d = times10(a_mag_q) + IW'(dig_a);
                b_mag_d = times10(b_mag_q) + IW'(dig_b);
                a_bcd_d = a_bcd_q << 4;
                b_bcd_d = b_bcd_q << 4;
                bad_d   = bad_q | (dig_a > 4'd9) | (dig_b > 4'd9);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(DIGIT_NUM - 1)) begin
                    r_mag_d = '0;
                    rem_d   = '0;
                    if (bad_d || (op_q > OP_DIV) || (op_q == OP_DIV && b_mag_d == '0)) begin
                        state_d       = S_DONE;
                        err_d         = 1'b1;
                        result_d      = '0;
                        result_sign_d = 1'b0;
                        result_dp_d   = '0;
                    end else begin
                        r_sign_d = a_sign_q ^ b_sign_q;
                        case (op_q)
                            OP_MUL: begin
                                k    = '0;
                                dp_d = XW'(a_dp_q) + XW'(b_dp_q);
                            end
                            OP_DIV: begin
                                k         = XW'(b_dp_q) + XW'(FRAC_DIGITS);
                                dp_d      = XW'(a_dp_q) + XW'(FRAC_DIGITS);
                                scale_a_d = 1'b1;
                            end
                            default: begin
                                if (a_dp_q >= b_dp_q) begin
                                    k         = XW'(a_dp_q - b_dp_q);
                                    dp_d      = XW'(a_dp_q);
                                    scale_a_d = 1'b0;
                                end else begin
                                    k         = XW'(b_dp_q - a_dp_q);
                                    dp_d      = XW'(b_dp_q);
                                    scale_a_d = 1'b1;
                                end
                            end
                        endcase
                        if (k == '0) begin
                            state_d = S_EXEC;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_SCALE;
                            cnt_d   = CW'(k);
                        end
                    end
                end
            end

            S_SCALE: begin
                if (scale_a_q) a_mag_d = times10(a_mag_q);
                else           b_mag_d = times10(b_mag_q);
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_EXEC;
            end

            S_EXEC: begin
                cnt_d = cnt_q + 1'b1;
                case (op_q)
                    OP_MUL: begin
                        if (b_mag_q[0]) r_mag_d = r_mag_q + a_mag_q;
                        a_mag_d = a_mag_q << 1;
                        b_mag_d = b_mag_q >> 1;
                        settle  = (cnt_q == CW'(MW - 1));
                    end
                    OP_DIV: begin
                        // divisor < 2^MW, so the borrow out of the MW+1 bit subtract is the compare
                        rem_sh  = {rem_q, a_mag_q[IW-1]};
                        diff    = rem_sh - {1'b0, b_mag_q[MW-1:0]};
                        rem_d   = diff[MW] ? rem_sh[MW-1:0] : diff[MW-1:0];
                        a_mag_d = {a_mag_q[IW-2:0], ~diff[MW]};
                        if (cnt_q == CW'(IW - 1)) begin
                            r_mag_d = a_mag_d;
                            settle  = 1'b1;
                        end
                    end
                    default: begin
                        b_neg = b_sign_q ^ (op_q == OP_SUB);
                        if (a_sign_q == b_neg) begin
                            sum       = {1'b0, a_mag_q} + {1'b0, b_mag_q};
                            r_mag_d   = sum[IW-1:0];
                            carry_ovf = sum[IW];
                            r_sign_d  = a_sign_q;
                        end else if (a_mag_q >= b_mag_q) begin
                            r_mag_d  = a_mag_q - b_mag_q;
                            r_sign_d = a_sign_q;
                        end else begin
                            r_mag_d  = b_mag_q - a_mag_q;
                            r_sign_d = b_neg;
                        end
                        settle = 1'b1;
                    end
                endcase
            end

            S_NORM: begin
                r_mag_d = r_mag_q / IW'(10);
                dp_d    = dp_q - 1'b1;
                settle  = 1'b1;
            end

            S_CONV: begin
                cy = r_mag_q[MW-1];
                for (int unsigned i = 0; i < DIGIT_NUM; i++) begin
                    dg = bcd_q[4*i +: 4];
                    if (dg >= 4'd5) dg = dg + 4'd3;
                    bcd_d[4*i +: 4] = {dg[2:0], cy};
                    cy = dg[3];
                end
                r_mag_d = r_mag_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(MW - 1)) begin
                    state_d       = S_DONE;
                    result_d      = bcd_d;
                    result_sign_d = r_sign_q;
                    result_dp_d   = dp_q[DP_W-1:0];
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // EXEC and NORM share one exit decision made on the freshly computed magnitude
        if (settle) begin
            r_sign_d = r_sign_d & (r_mag_d != '0);
            big      = (r_mag_d >= LIMIT);
            if ((dp_d > XW'(DIGIT_NUM - 1) || big) && dp_d != '0 && !carry_ovf) begin
                state_d = S_NORM;
            end else if (big || carry_ovf) begin
                state_d       = S_DONE;
                overflow_d    = 1'b1;
                result_d      = '0;
                result_sign_d = 1'b0;
                result_dp_d   = '0;
            end else begin
                state_d = S_CONV;
                cnt_d   = '0;
                bcd_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            a_sign_q      <= 1'b0;
            b_sign_q      <= 1'b0;
            a_bcd_q       <= '0;
            b_bcd_q       <= '0;
            a_dp_q        <= '0;
            b_dp_q        <= '0;
            a_mag_q       <= '0;
            b_mag_q       <= '0;
            r_mag_q       <= '0;
            rem_q         <= '0;
            bcd_q         <= '0;
            dp_q          <= '0;
            cnt_q         <= '0;
            bad_q         <= 1'b0;
            scale_a_q     <= 1'b0;
            r_sign_q      <= 1'b0;
            result_q      <= '0;
            result_sign_q <= 1'b0;
            result_dp_q   <= '0;
            overflow_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_sign_q      <= a_sign_d;
            b_sign_q      <= b_sign_d;
            a_bcd_q       <= a_bcd_d;
            b_bcd_q       <= b_bcd_d;
            a_dp_q        <= a_dp_d;
            b_dp_q        <= b_dp_d;
            a_mag_q       <= a_mag_d;
            b_mag_q       <= b_mag_d;
            r_mag_q       <= r_mag_d;
            rem_q         <= rem_d;
            bcd_q         <= bcd_d;
            dp_q          <= dp_d;
            cnt_q         <= cnt_d;
            bad_q         <= bad_d;
            scale_a_q     <= scale_a_d;
            r_sign_q      <= r_sign_d;
            result_q      <= result_d;
            result_sign_q <= result_sign_d;
            result_dp_q   <= result_dp_d;
            overflow_q    <= overflow_d;
            err_q         <= err_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.result      = result_q;
    assign bus.result_sign = result_sign_q;
    assign bus.result_dp   = result_dp_q;
    assign bus.overflow    = overflow_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq: a decimal reference model predicts value, flags
// and completion cycle for each request; a monitor checks every done pulse.
module tb_bcd_alu_seq;
    localparam int DIGIT_NUM   = 8;
    localparam int DP_W        = 3;
    localparam int FRAC_DIGITS = 4;
    localparam int IW          = 64;
    localparam int MW          = 4 * DIGIT_NUM;

    typedef struct {
        string           name;
        logic [MW-1:0]   res;
        bit              sgn;
        logic [DP_W-1:0] dp;
        bit              ovf;
        bit              err;
        longint unsigned t;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    longint unsigned cyc = 0;
    int              tests = 0;
    int              fails = 0;
    exp_t            sbq[$];
    exp_t            mon_x;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_alu_seq_if #(.DIGIT_NUM(DIGIT_NUM), .DP_W(DP_W)) bus ();

    bcd_alu_seq #(
        .DIGIT_NUM  (DIGIT_NUM),
        .DP_W       (DP_W),
        .FRAC_DIGITS(FRAC_DIGITS),
        .IW         (IW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic longint unsigned p10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit bcd2bin(input logic [MW-1:0] v, output longint unsigned m);
        logic [3:0] d;
        bit ok = 1;
        m = 0;
        for (int i = DIGIT_NUM - 1; i >= 0; i--) begin
            d = v[4*i +: 4];
            if (d > 4'd9) ok = 0;
            m = m * 10 + longint'(d);
        end
        return ok;
    endfunction

    function automatic logic [MW-1:0] bin2bcd(input longint unsigned m);
        logic [MW-1:0] r = '0;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Decimal reference: align points, compute exactly, drop digits until it fits.
    function automatic exp_t model(input string name, input logic [2:0] op, input bit as_, input bit bs_,
                                   input logic [MW-1:0] a, input logic [MW-1:0] b,
                                   input int adp, input int bdp, input longint unsigned e);
        exp_t x;
        longint unsigned am, bm, mag;
        int dp, k, ex, n;
        bit sgn, bn, oka, okb;
        x.name = name; x.res = '0; x.sgn = 0; x.dp = '0; x.ovf = 0; x.err = 0;
        oka = bcd2bin(a, am);
        okb = bcd2bin(b, bm);
        if (!oka || !okb || op > 3 || (op == 3 && bm == 0)) begin
            x.err = 1;
            x.t   = e + DIGIT_NUM;
            return x;
        end
        mag = 0; dp = 0; k = 0; ex = 0; sgn = 0;
        case (op)
            3'd2: begin
                mag = am * bm; dp = adp + bdp; sgn = as_ ^ bs_; ex = MW;
            end
            3'd3: begin
                k = bdp + FRAC_DIGITS; mag = (am * p10(k)) / bm;
                dp = adp + FRAC_DIGITS; sgn = as_ ^ bs_; ex = IW;
            end
            default: begin
                dp = (adp > bdp) ? adp : bdp;
                k  = (adp > bdp) ? adp - bdp : bdp - adp;
                am = am * p10(dp - adp);
                bm = bm * p10(dp - bdp);
                bn = bs_ ^ (op == 3'd1);
                if (as_ == bn)     begin mag = am + bm; sgn = as_; end
                else if (am >= bm) begin mag = am - bm; sgn = as_; end
                else               begin mag = bm - am; sgn = bn;  end
                ex = 1;
            end
        endcase
        n = 0;
        while ((dp > DIGIT_NUM - 1 || mag >= p10(DIGIT_NUM)) && dp > 0) begin
            mag = mag / 10; dp--; n++;
        end
        if (mag >= p10(DIGIT_NUM)) begin
            x.ovf = 1;
            x.t   = e + DIGIT_NUM + k + ex + n;
        end else begin
            x.res = bin2bcd(mag);
            x.sgn = sgn && (mag != 0);
            x.dp  = DP_W'(dp);
            x.t   = e + DIGIT_NUM + k + ex + n + MW;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                mon_x = sbq.pop_front();
                check({mon_x.name, ".result"}, bus.result, mon_x.res);
                check({mon_x.name, ".sign"}, bus.result_sign, mon_x.sgn);
                check({mon_x.name, ".dp"}, bus.result_dp, mon_x.dp);
                check({mon_x.name, ".overflow"}, bus.overflow, mon_x.ovf);
                check({mon_x.name, ".err"}, bus.err, mon_x.err);
                check({mon_x.name, ".done_cycle"}, cyc, mon_x.t);
                check({mon_x.name, ".busy_low"}, bus.busy, 0);
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input bit as_, input bit bs_,
                         input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic [DP_W-1:0] adp, input logic [DP_W-1:0] bdp);
        int guard = 0;
        while ((bus.busy || bus.done) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            tests++; fails++;
            $display("FAIL %s.idle_wait: got busy after %0d cycles, expected idle", name, guard);
        end
        bus.start = 1'b1; bus.op = op; bus.a_sign = as_; bus.b_sign = bs_;
        bus.a = a; bus.b = b; bus.a_dp = adp; bus.b_dp = bdp;
        sbq.push_back(model(name, op, as_, bs_, a, b, int'(adp), int'(bdp), cyc + 1));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sbq.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: got %0d pending results, expected 0", sbq.size());
            sbq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [MW-1:0] rand_bcd(input bit allow_bad);
        logic [MW-1:0] r;
        int nd = $urandom_range(1, DIGIT_NUM);
        r = bin2bcd(longint'($urandom_range(0, 32'(p10(nd) - 1))));
        if (allow_bad && $urandom_range(0, 15) == 0)
            r[4*$urandom_range(0, DIGIT_NUM - 1) +: 4] = 4'(10 + $urandom_range(0, 5));
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        logic [MW-1:0] ra, rb;
        longint unsigned e;

        bus.start = 1'b0; bus.op = '0; bus.a_sign = 1'b0; bus.b_sign = 1'b0;
        bus.a = '0; bus.b = '0; bus.a_dp = '0; bus.b_dp = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        check("reset.result", bus.result, 0);
        check("reset.sign", bus.result_sign, 0);
        check("reset.dp", bus.result_dp, 0);
        check("reset.overflow", bus.overflow, 0);
        check("reset.err", bus.err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("add_12.5+3.25", 3'd0, 0, 0, 32'h00000125, 32'h00000325, 3'd1, 3'd2);
        issue("sub_3-10", 3'd1, 0, 0, 32'h00000003, 32'h00000010, 3'd0, 3'd0);
        issue("mul_max_dp4", 3'd2, 0, 0, 32'h99999999, 32'h99999999, 3'd4, 3'd4);
        issue("div_1/3", 3'd3, 0, 0, 32'h00000001, 32'h00000003, 3'd0, 3'd0);
        issue("div_by_zero", 3'd3, 0, 0, 32'h00000042, 32'h00000000, 3'd0, 3'd0);
        issue("add_overflow", 3'd0, 0, 0, 32'h99999999, 32'h00000001, 3'd0, 3'd0);
        issue("neg_mul", 3'd2, 1, 0, 32'h00001234, 32'h00000056, 3'd2, 3'd1);
        check("flag_clear.overflow", bus.overflow, 0);
        issue("bad_digit", 3'd0, 0, 0, 32'h000A0001, 32'h00000001, 3'd0, 3'd0);
        issue("invalid_op", 3'd5, 0, 0, 32'h00000001, 32'h00000001, 3'd0, 3'd0);
        issue("zero_sign", 3'd1, 1, 1, 32'h00000500, 32'h00000500, 3'd2, 3'd2);
        issue("div_max_dp", 3'd3, 1, 0, 32'h99999999, 32'h00000007, 3'd7, 3'd7);
        drain();

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            ra = rand_bcd(1);
            rb = rand_bcd(1);
            if (op == 3'd3 && $urandom_range(0, 7) == 0) rb = '0;
            issue($sformatf("rand%0d", i), op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ra, rb, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        drain();

        issue("mul_ignore_start", 3'd2, 0, 0, 32'h99999999, 32'h99999999, 3'd4, 3'd4);
        repeat (18) @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h00000001; bus.b = 32'h00000001;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (60) @(negedge clk);

        e = cyc + 1;
        issue("aborted_add", 3'd0, 0, 0, 32'h00000011, 32'h00000022, 3'd0, 3'd0);
        while (cyc < e + DIGIT_NUM + 1 + 10) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("midreset.busy", bus.busy, 0);
        check("midreset.done", bus.done, 0);
        check("midreset.result", bus.result, 0);
        check("midreset.sign", bus.result_sign, 0);
        check("midreset.dp", bus.result_dp, 0);
        check("midreset.overflow", bus.overflow, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);

        issue("add_2+2", 3'd0, 0, 0, 32'h00000002, 32'h00000002, 3'd0, 3'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
